// File: rtl/float_addsub_seq.sv
// Multi-cycle floating-point add/subtract with valid/ready handshakes on both sides.
// State table:  IDLE | waiting for operands      CMP  | compare, swap, shift count
//               ALIGN | shift small significand   ADD  | add/sub significands
//               NORM  | normalise, pack result    DONE | result held until accepted
module float_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op_sub,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic                   out_ovf,
    output logic                   out_zero
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SW    = MAN_W + 2;
    localparam int CNT_W = $clog2(SW + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMP, S_ALIGN, S_ADD, S_NORM, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]     a_r, b_r;
    logic             sign_r, sub_r;
    logic [EXP_W-1:0] exp_r;
    logic [SW-1:0]    sig_big, sig_small, sum;
    logic [CNT_W-1:0] cnt;

    logic [EXP_W-1:0] ea, eb;
    logic [SW-1:0]    siga, sigb;
    logic [EXP_W:0]   d, d_abs;
    logic [31:0]      d_abs32;
    logic             a_big;
    logic [CNT_W-1:0] cnt_init;
    logic [EXP_W:0]   exp_inc;
    logic             ovf_hit, sum_zero, carry, hidden, norm_done;

    // Operand decode: exponent zero means the value is zero.
    always_comb begin
        ea       = a_r[W-2:MAN_W];
        eb       = b_r[W-2:MAN_W];
        siga     = (ea == '0) ? '0 : {2'b01, a_r[MAN_W-1:0]};
        sigb     = (eb == '0) ? '0 : {2'b01, b_r[MAN_W-1:0]};
        d        = {1'b0, ea} - {1'b0, eb};
        d_abs    = d[EXP_W] ? (~d + 1'b1) : d;
        d_abs32  = 32'(d_abs);
        a_big    = (ea > eb) || ((ea == eb) && (siga >= sigb));
        cnt_init = (d_abs32 > 32'(SW)) ? CNT_W'(SW) : CNT_W'(d_abs32);
    end

    always_comb begin
        exp_inc   = {1'b0, exp_r} + 1'b1;
        ovf_hit   = exp_inc >= {1'b0, {EXP_W{1'b1}}};
        sum_zero  = (sum == '0);
        carry     = sum[SW-1];
        hidden    = sum[SW-2];
        norm_done = sum_zero || carry || hidden || (exp_r == EXP_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_CMP;
            end
            S_CMP:   state_nxt = S_ALIGN;
            // Leave on the cycle that performs the last shift, so occupancy is max(1, count).
            S_ALIGN: if (cnt <= CNT_W'(1)) state_nxt = S_ADD;
            S_ADD:   state_nxt = S_NORM;
            S_NORM:  if (norm_done) state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= '0;
            b_r       <= '0;
            sign_r    <= 1'b0;
            sub_r     <= 1'b0;
            exp_r     <= '0;
            sig_big   <= '0;
            sig_small <= '0;
            sum       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    a_r <= a;
                    b_r <= {b[W-1] ^ op_sub, b[W-2:0]};
                end
                S_CMP: begin
                    sign_r    <= a_big ? a_r[W-1] : b_r[W-1];
                    sub_r     <= a_r[W-1] ^ b_r[W-1];
                    exp_r     <= a_big ? ea : eb;
                    sig_big   <= a_big ? siga : sigb;
                    sig_small <= a_big ? sigb : siga;
                    cnt       <= cnt_init;
                end
                S_ALIGN: if (cnt != '0) begin
                    sig_small <= sig_small >> 1;
                    cnt       <= cnt - 1'b1;
                end
                S_ADD: sum <= sub_r ? (sig_big - sig_small) : (sig_big + sig_small);
                S_NORM: begin
                    if (sum_zero) begin
                        out_data <= '0;
                        out_ovf  <= 1'b0;
                        out_zero <= 1'b1;
                    end else if (carry) begin
                        out_zero <= 1'b0;
                        if (ovf_hit) begin
                            out_data <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            out_ovf  <= 1'b1;
                        end else begin
                            out_data <= {sign_r, exp_inc[EXP_W-1:0], sum[MAN_W:1]};
                            out_ovf  <= 1'b0;
                        end
                    end else if (hidden) begin
                        out_data <= {sign_r, exp_r, sum[MAN_W-1:0]};
                        out_ovf  <= 1'b0;
                        out_zero <= 1'b0;
                    end else if (exp_r == EXP_W'(1)) begin
                        // Would underflow into the denormal range: flush to +0.
                        out_data <= '0;
                        out_ovf  <= 1'b0;
                        out_zero <= 1'b1;
                    end else begin
                        sum   <= sum << 1;
                        exp_r <= exp_r - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
